// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first,
// sequenced by a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             brw;
    logic [CNT_W-1:0] cnt;

    logic             bit_d;
    logic             brw_next;
    logic             last_bit;

    // Single full-subtractor cell operating on the current LSBs.
    always_comb begin
        bit_d    = a_sr[0] ^ b_sr[0] ^ brw;
        brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        brw    <= bin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= StShift;
                    end else begin
                        state <= StIdle;
                    end
                end
                StShift: begin
                    res_sr <= {bit_d, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    brw    <= brw_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // Publish the result including the bit computed on this edge.
                        diff  <= {bit_d, res_sr[WIDTH-1:1]};
                        bout  <= brw_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results and timing,
// a negedge monitor compares busy, done, diff and bout against them.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int diff;
        int bout;
        int due;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   bs = 1;
    int   be = 0;

    task automatic check(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, wanted %0d (cycle %0d, t=%0t)", name, act, req, cyc,
                     $time);
        end
    endtask

    // Reference: plain integer subtraction; sign gives the borrow, low bits give diff.
    function automatic exp_t model(input int ai, input int bi, input int ci, input int due);
        exp_t e;
        int   r;
        r      = ai - bi - ci;
        e.bout = (r < 0) ? 1 : 0;
        e.diff = r & ((1 << W) - 1);
        e.due  = due;
        return e;
    endfunction

    // Monitor: busy window and done cycle come from the stimulus, data from the queue.
    logic         prev_busy = 1'b0;
    logic [W-1:0] prev_diff = '0;
    always @(negedge clk) begin : mon
        exp_t e;
        int   exp_done;
        if (!rst) begin
            exp_done = (q.size() > 0 && q[0].due == cyc) ? 1 : 0;
            check("busy", int'(busy), (cyc >= bs && cyc <= be) ? 1 : 0);
            check("done", int'(done), exp_done);
            if (busy && prev_busy) check("diff_stable_while_busy", int'(diff), int'(prev_diff));
            if (done && q.size() > 0) begin
                e = q.pop_front();
                check("diff", int'(diff), e.diff);
                check("bout", int'(bout), e.bout);
            end
        end
        prev_busy = busy;
        prev_diff = diff;
    end

    // Called just after a rising edge with the DUT in IDLE or DONE; returns just after the
    // completion edge, with the DUT in DONE.
    task automatic issue(input int ai, input int bi, input int ci, input bit chaos,
                         input bit hold);
        a     = W'(ai);
        b     = W'(bi);
        bin   = ci[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model(ai, bi, ci, cyc + W));
        bs    = cyc;
        be    = cyc + W - 1;
        start = hold;
        for (int i = 0; i < W; i++) begin
            if (chaos) begin
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom);
                start = 1'($urandom);
            end
            @(posedge clk);
            #1;
        end
        start = hold;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_diff", int'(diff), 0);
        check("reset_bout", int'(bout), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // Directed cases.
        issue(0, 1, 0, 0, 0);
        idle(2);
        issue(15, 1, 0, 0, 0);
        issue(10, 3, 1, 0, 0);
        idle(1);
        issue(0, 0, 1, 0, 0);
        issue(7, 7, 0, 0, 0);
        idle(1);

        // Exhaustive sweep, mixing back-to-back and gapped starts.
        for (int ai = 0; ai < (1 << W); ai++)
            for (int bi = 0; bi < (1 << W); bi++)
                for (int ci = 0; ci < 2; ci++) begin
                    issue(ai, bi, ci, 0, 0);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                end

        // Inputs and start toggled randomly while busy.
        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1)), 1, 0);
            if ($urandom_range(0, 1) == 0) idle(1);
        end
        idle(2);

        // start held high: a new operation every W+1 cycles.
        for (int i = 0; i < 5; i++) issue(5, 3, 0, 0, (i < 4) ? 1'b1 : 1'b0);
        idle(2);

        // Asynchronous reset after two bits of an operation.
        a     = 4'd9;
        b     = 4'd2;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bs = cyc;
        be = cyc + W - 1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        bs = 1;
        be = 0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_diff", int'(diff), 0);
        check("async_rst_bout", int'(bout), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        issue(12, 5, 1, 0, 0);
        issue(3, 9, 0, 0, 0);
        idle(3);

        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
